// File: rtl/pol2rec_pkg.sv
// Shared constants for the polar-to-rectangular CORDIC: angle landmarks, gain
// compensation factor, arctangent table (degrees Q.10) and FSM encodings.
package pol2rec_pkg;

  localparam int ANGLE_W = 19;
  localparam int MAG_W   = 12;
  localparam int OUT_W   = 13;

  localparam logic signed [ANGLE_W-1:0] DEG90  = 19'sh16800;
  localparam logic signed [ANGLE_W-1:0] DEG180 = 19'sh2D000;

  // 0.607253 in Q0.16; applied to the magnitude before rotating.
  localparam logic [15:0] CORDIC_K = 16'd39797;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  function automatic logic [ANGLE_W-1:0] atan_lookup(input logic [3:0] idx);
    logic [ANGLE_W-1:0] v;
    case (idx)
      4'd0:    v = 19'd46080;
      4'd1:    v = 19'd27203;
      4'd2:    v = 19'd14373;
      4'd3:    v = 19'd7296;
      4'd4:    v = 19'd3662;
      4'd5:    v = 19'd1833;
      4'd6:    v = 19'd917;
      4'd7:    v = 19'd458;
      4'd8:    v = 19'd229;
      4'd9:    v = 19'd115;
      4'd10:   v = 19'd57;
      4'd11:   v = 19'd29;
      4'd12:   v = 19'd14;
      4'd13:   v = 19'd7;
      4'd14:   v = 19'd4;
      default: v = 19'd2;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pol2rec_atan_rom.sv
// Combinational arctangent lookup, indexed by the CORDIC iteration counter.
module pol2rec_atan_rom
  import pol2rec_pkg::*;
(
  input  logic [3:0]         idx,
  output logic [ANGLE_W-1:0] atan_val
);

  assign atan_val = atan_lookup(idx);

endmodule

// File: rtl/pol2rec_calc.sv
// Iterative rotation-mode CORDIC: (mag, angle in degrees Q9.10) -> signed X/Y.
// One micro-rotation per clock; result registered with a one-cycle valid pulse.
module pol2rec_calc
  import pol2rec_pkg::*;
#(
  parameter int NITER = 16,
  parameter int GUARD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] mag,
  input  logic [18:0] angle,
  output logic        busy,
  output logic        valid,
  output logic [12:0] X,
  output logic [12:0] Y
);

  localparam int XW = OUT_W + GUARD + 1;
  localparam logic signed [XW:0] RND    = (XW + 1)'(1) << (GUARD - 1);
  localparam logic signed [XW:0] SAT_HI = (XW + 1)'(4095);
  localparam logic signed [XW:0] SAT_LO = -SAT_HI;

  logic [1:0]                 state;
  logic [3:0]                 iter;
  logic signed [XW-1:0]       x_r, y_r;
  logic signed [ANGLE_W-1:0]  z_r;

  logic signed [ANGLE_W-1:0]  ang_c, z0;
  logic [27:0]                mag_prod;
  logic signed [XW-1:0]       magk, x0;
  logic signed [XW-1:0]       x_sh, y_sh, x_nx, y_nx;
  logic signed [ANGLE_W-1:0]  z_nx;
  logic [ANGLE_W-1:0]         atan_val;
  logic signed [XW:0]         x_ext, y_ext, x_rnd, y_rnd;

  pol2rec_atan_rom u_atan_rom (
    .idx      (iter),
    .atan_val (atan_val)
  );

  function automatic logic [OUT_W-1:0] sat13(input logic signed [XW:0] v);
    logic [OUT_W-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO) r = SAT_LO[OUT_W-1:0];
    else                 r = v[OUT_W-1:0];
    return r;
  endfunction

  // Clamp, gain-compensate and fold the angle into [-90, +90] at latch time.
  always_comb begin
    ang_c = $signed(angle);
    if ($signed(angle) > DEG180)       ang_c = DEG180;
    else if ($signed(angle) < -DEG180) ang_c = -DEG180;
    mag_prod = 28'(mag) * 28'(CORDIC_K);
    magk     = $signed(XW'(mag_prod >> (16 - GUARD)));
    if (ang_c > DEG90) begin
      z0 = ang_c - DEG180;
      x0 = -magk;
    end else if (ang_c < -DEG90) begin
      z0 = ang_c + DEG180;
      x0 = -magk;
    end else begin
      z0 = ang_c;
      x0 = magk;
    end
  end

  always_comb begin
    x_sh = x_r >>> iter;
    y_sh = y_r >>> iter;
    if (z_r >= 0) begin
      x_nx = x_r - y_sh;
      y_nx = y_r + x_sh;
      z_nx = z_r - $signed(atan_val);
    end else begin
      x_nx = x_r + y_sh;
      y_nx = y_r - x_sh;
      z_nx = z_r + $signed(atan_val);
    end
  end

  // Round half up, then drop the guard bits; one extra bit keeps the add safe.
  always_comb begin
    x_ext = x_r;
    y_ext = y_r;
    x_rnd = (x_ext + RND) >>> GUARD;
    y_rnd = (y_ext + RND) >>> GUARD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      iter  <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      X     <= '0;
      Y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_r   <= x0;
            y_r   <= '0;
            z_r   <= z0;
            iter  <= '0;
            state <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          if (iter == 4'(NITER - 1)) state <= ST_FINISH;
          else                       iter  <= iter + 4'd1;
        end
        ST_FINISH: begin
          X     <= sat13(x_rnd);
          Y     <= sat13(y_rnd);
          valid <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_ROTATE) || (state == ST_FINISH);

endmodule

// File: tb/tb_pol2rec_calc.sv
// Directed bench for pol2rec_calc: expected X/Y (with tolerance) are queued on
// issue and checked by an independent monitor whenever valid pulses.
module tb_pol2rec_calc;

  localparam int NITER = 16;
  localparam int LAT   = NITER + 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] mag;
  logic [18:0] angle;
  logic        busy;
  logic        valid;
  logic [12:0] X;
  logic [12:0] Y;

  int total = 0;
  int bad   = 0;

  // {tol[5:0], exp_x[12:0], exp_y[12:0]}
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  pol2rec_calc #(.NITER(NITER), .GUARD(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mag   (mag),
    .angle (angle),
    .busy  (busy),
    .valid (valid),
    .X     (X),
    .Y     (Y)
  );

  function automatic logic [31:0] pack_exp(input int ex, input int ey, input int tol);
    logic [5:0]  t;
    logic [12:0] xx, yy;
    t  = 6'(tol);
    xx = 13'(ex);
    yy = 13'(ey);
    return {t, xx, yy};
  endfunction

  // Monitor / scoreboard
  logic [31:0] mon_e;
  int mon_ex, mon_ey, mon_tol, mon_ax, mon_ay, mon_dx, mon_dy;

  always @(negedge clock) begin
    if (valid) begin
      total++;
      mon_ax = int'($signed(X));
      mon_ay = int'($signed(Y));
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid X=%0d Y=%0d required=no output", mon_ax, mon_ay);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_tol = int'(mon_e[31:26]);
        mon_ex  = int'($signed(mon_e[25:13]));
        mon_ey  = int'($signed(mon_e[12:0]));
        mon_dx  = mon_ax - mon_ex;
        mon_dy  = mon_ay - mon_ey;
        if (mon_dx < 0) mon_dx = -mon_dx;
        if (mon_dy < 0) mon_dy = -mon_dy;
        if (mon_dx > mon_tol || mon_dy > mon_tol) begin
          bad++;
          $display("FAIL xy_result X=%0d Y=%0d required X=%0d Y=%0d (+/-%0d)",
                   mon_ax, mon_ay, mon_ex, mon_ey, mon_tol);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (start sampled in cycle 0).
  task automatic issue(input int m, input int a, input int ex, input int ey,
                       input int tol, input bit expect_out);
    mag   = 12'(m);
    angle = 19'(a);
    start = 1'b1;
    if (expect_out) exp_q.push_back(pack_exp(ex, ey, tol));
    @(negedge clock);
    start = 1'b0;
  endtask

  // n0 = cycle number of the current negedge relative to the accepted start.
  task automatic wait_valid(input string name, input int n0);
    int n;
    n = n0;
    while (!valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (!valid || n != LAT) begin
      bad++;
      $display("FAIL %s_latency valid=%0b cycle=%0d required cycle=%0d", name, valid, n, LAT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mag   = '0;
    angle = '0;
    repeat (3) @(negedge clock);
    check("reset_X", int'($signed(X)), 0);
    check("reset_Y", int'($signed(Y)), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clock);

    // 0 degrees, with latency and busy checks
    issue(1000, 0, 1000, 0, 2, 1'b1);
    check("busy_during", int'(busy), 1);
    wait_valid("deg0", 1);
    check("busy_in_valid_cycle", int'(busy), 0);
    @(negedge clock);
    check("busy_after", int'(busy), 0);
    check("valid_one_cycle", int'(valid), 0);

    issue(1000, 32'h16800, 0, 1000, 2, 1'b1);
    wait_valid("deg90", 1);
    issue(1000, 32'h2D000, -1000, 0, 2, 1'b1);
    wait_valid("deg180", 1);
    issue(1000, -32'sh2D000, -1000, 0, 2, 1'b1);
    wait_valid("degm180", 1);
    issue(4095, -32'sh21C00, -2896, -2896, 2, 1'b1);
    wait_valid("degm135", 1);
    issue(4095, 0, 4095, 0, 2, 1'b1);
    wait_valid("fullscale", 1);
    issue(500, 32'h3FFFF, -500, 0, 2, 1'b1);
    wait_valid("clamp_hi", 1);
    issue(500, -32'sh3F000, -500, 0, 2, 1'b1);
    wait_valid("clamp_lo", 1);
    issue(0, 30720, 0, 0, 0, 1'b1);
    wait_valid("mag0_a", 1);
    issue(0, -102400, 0, 0, 0, 1'b1);
    wait_valid("mag0_b", 1);

    // start while busy is ignored: only the 45 degree result appears
    @(negedge clock);
    issue(800, 32'h0B400, 566, 566, 2, 1'b1);
    repeat (3) @(negedge clock);
    mag   = 12'd100;
    angle = 19'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_valid("busy_ignore", 5);
    repeat (25) @(negedge clock);

    // reset mid-conversion discards the result and clears outputs
    issue(700, 0, 0, 0, 0, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_busy", int'(busy), 0);
    check("midreset_X", int'($signed(X)), 0);
    check("midreset_Y", int'($signed(Y)), 0);
    repeat (25) @(negedge clock);

    // back-to-back: start in the valid cycle is accepted
    issue(1000, 0, 1000, 0, 2, 1'b1);
    wait_valid("b2b_first", 1);
    issue(1000, 32'h16800, 0, 1000, 2, 1'b1);
    wait_valid("b2b_second", 1);

    // sweep -180..+180 degrees at mag 2048 against a real-valued reference
    for (int d = -180; d <= 180; d++) begin
      real r;
      int  ex, ey;
      r  = real'(d) * 3.14159265358979 / 180.0;
      ex = int'(2048.0 * $cos(r));
      ey = int'(2048.0 * $sin(r));
      issue(2048, d * 1024, ex, ey, 2, 1'b1);
      wait_valid("sweep", 1);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
